// File: rtl/player_move_ctrl.sv
// Player movement/score controller: tick divider, button arbitration, hit detection, respawn handshake.
// Optional DIAGONAL_MOVE_EN: arbitrate vertical and horizontal axes independently on each tick.
module player_move_ctrl #(
   parameter int unsigned TICK_DIV      = 500000,
   parameter int unsigned PLAYER_SIZE   = 16,
   parameter int unsigned POINT_SIZE    = 8,
   parameter int unsigned SCREEN_WIDTH  = 800,
   parameter int unsigned SCREEN_HEIGHT = 600,
   parameter int unsigned START_X       = 32,
   parameter int unsigned START_Y       = 32,
   parameter int unsigned SCORE_MAX     = 99
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       move_up,
   input  logic       move_down,
   input  logic       move_right,
   input  logic       move_left,
   input  logic       collision_up,
   input  logic       collision_down,
   input  logic       collision_right,
   input  logic       collision_left,
   input  logic [9:0] point_x,
   input  logic [9:0] point_y,
   input  logic       respawn_ack,
   output logic       respawn_req,
   output logic [9:0] xpos,
   output logic [9:0] ypos,
   output logic [7:0] score,
   output logic [1:0] state,
   output logic       tick
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_PLAY    = 2'd1,
      S_RESPAWN = 2'd2,
      S_WIN     = 2'd3
   } state_e;

   localparam int unsigned      DIV_W    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
   localparam logic [10:0]      HIT_DIST = 11'(PLAYER_SIZE + POINT_SIZE);
   localparam logic [10:0]      LO_LIM   = 11'(PLAYER_SIZE);
   localparam logic [10:0]      X_LIM    = 11'(SCREEN_WIDTH - PLAYER_SIZE);
   localparam logic [10:0]      Y_LIM    = 11'(SCREEN_HEIGHT - PLAYER_SIZE);

   state_e           state_q, state_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [9:0]       xpos_q, xpos_d;
   logic [9:0]       ypos_q, ypos_d;
   logic [7:0]       score_q, score_d;

   logic        tick_w, hit_w;
   logic [10:0] x11, y11, px11, py11, dx_abs, dy_abs;
   logic        up_ok, down_ok, right_ok, left_ok;
   logic        can_up, can_down, can_right, can_left;
   logic [9:0]  nx, ny;

   // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         div_q   <= '0;
         xpos_q  <= 10'(START_X);
         ypos_q  <= 10'(START_Y);
         score_q <= '0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         xpos_q  <= xpos_d;
         ypos_q  <= ypos_d;
         score_q <= score_d;
      end
   end

   // Bounds and overlap are evaluated in 11 bits so subtraction cannot wrap.
   always_comb begin
      x11    = {1'b0, xpos_q};
      y11    = {1'b0, ypos_q};
      px11   = {1'b0, point_x};
      py11   = {1'b0, point_y};
      dx_abs = (x11 >= px11) ? (x11 - px11) : (px11 - x11);
      dy_abs = (y11 >= py11) ? (y11 - py11) : (py11 - y11);
      hit_w  = (state_q == S_PLAY) && (dx_abs < HIT_DIST) && (dy_abs < HIT_DIST);
      tick_w = (state_q == S_PLAY) && (div_q == DIV_LAST);

      up_ok    = move_up    & ~collision_up;
      down_ok  = move_down  & ~collision_down;
      right_ok = move_right & ~collision_right;
      left_ok  = move_left  & ~collision_left;

      can_up    = y11 > LO_LIM;
      can_down  = (y11 + 11'd1) < Y_LIM;
      can_right = (x11 + 11'd1) < X_LIM;
      can_left  = x11 > LO_LIM;
   end

   // NOTE: defaults first so every path assigns nx/ny and no latch is inferred.
   always_comb begin
      nx = xpos_q;
      ny = ypos_q;
`ifdef DIAGONAL_MOVE_EN
      if (up_ok) begin
         if (can_up) ny = ypos_q - 10'd1;
      end else if (down_ok) begin
         if (can_down) ny = ypos_q + 10'd1;
      end
      if (right_ok) begin
         if (can_right) nx = xpos_q + 10'd1;
      end else if (left_ok) begin
         if (can_left) nx = xpos_q - 10'd1;
      end
`else
      // The winning direction is final even when its bound blocks it.
      if (up_ok) begin
         if (can_up) ny = ypos_q - 10'd1;
      end else if (down_ok) begin
         if (can_down) ny = ypos_q + 10'd1;
      end else if (right_ok) begin
         if (can_right) nx = xpos_q + 10'd1;
      end else if (left_ok) begin
         if (can_left) nx = xpos_q - 10'd1;
      end
`endif
   end

   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      xpos_d  = xpos_q;
      ypos_d  = ypos_q;
      score_d = score_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_PLAY;
               div_d   = '0;
            end
         end
         S_PLAY: begin
            div_d = tick_w ? '0 : div_q + DIV_W'(1);
            if (tick_w) begin
               xpos_d = nx;
               ypos_d = ny;
            end
            if (hit_w) begin
               if (score_q < 8'(SCORE_MAX)) score_d = score_q + 8'd1;
               state_d = (({1'b0, score_q} + 9'd1) == 9'(SCORE_MAX)) ? S_WIN : S_RESPAWN;
            end
         end
         S_RESPAWN: begin
            if (respawn_ack) begin
               state_d = S_PLAY;
               div_d   = '0;
            end
         end
         S_WIN: begin
            if (start) begin
               state_d = S_PLAY;
               div_d   = '0;
               xpos_d  = 10'(START_X);
               ypos_d  = 10'(START_Y);
               score_d = '0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      respawn_req = (state_q == S_RESPAWN);
      tick        = tick_w;
      state       = state_q;
      xpos        = xpos_q;
      ypos        = ypos_q;
      score       = score_q;
   end

endmodule

// File: doc/player_move_ctrl.md
Name: player_move_ctrl

Overview:
Game-level controller that sequences the player-square datapath. It owns the movement tick divider, arbitrates the four direction buttons against collision flags and screen bounds, and keeps the registered player position. It detects player/point overlap, counts score, and runs a req/ack handshake with the random point generator to request a new point position. Its xpos/ypos/score outputs drive the rectangle draw stage and the HUD.

Parameters:
TICK_DIV, 500000, clk cycles per movement tick (≥2)
PLAYER_SIZE, 16, player half-size in pixels
POINT_SIZE, 8, point half-size in pixels
SCREEN_WIDTH, 800, active width in pixels
SCREEN_HEIGHT, 600, active height in pixels
START_X, 32, player x after reset or restart
START_Y, 32, player y after reset or restart
SCORE_MAX, 99, score that ends the game (≤255)

Ports:
clk  in  1  pixel-domain clock
rst_n  in  1  async active-low reset
start  in  1  level; starts or restarts the game
move_up, move_down, move_right, move_left  in  1 each  button levels, already synchronised
collision_up, collision_down, collision_right, collision_left  in  1 each  wall-collision flags for the current xpos/ypos
point_x, point_y  in  10 each  current point centre
respawn_ack  in  1  generator has a new point_x/point_y valid
respawn_req  out  1  request for a new point
xpos, ypos  out  10 each  player centre, registered
score  out  8  points collected
state  out  2  0 IDLE, 1 PLAY, 2 RESPAWN, 3 WIN
tick  out  1  one-cycle movement strobe

Behaviour:
- Reset (async assert, sync release): state=IDLE, xpos=START_X, ypos=START_Y, score=0, respawn_req=0, tick=0, divider=0.
- Divider: counts only in PLAY, from 0 to TICK_DIV-1, then wraps. tick=1 for one cycle when the divider is at TICK_DIV-1. Divider clears on every entry to PLAY. Leaving PLAY freezes it.
- FSM:
  - IDLE: start=1 → PLAY.
  - PLAY: hit → score+1. If the new score equals SCORE_MAX → WIN, else → RESPAWN.
  - RESPAWN: respawn_req=1, held until the cycle after respawn_ack=1 is sampled. Then req drops and state → PLAY.
  - WIN: start=1 → reload START_X/START_Y, score=0, → PLAY.
- Movement happens only on tick in PLAY, one pixel per tick. Arbitration is fixed priority: up > down > right > left.
  - A direction is eligible only if its button=1 and its collision flag=0.
  - Only the highest-priority eligible direction moves.
- Bounds, computed in 11-bit unsigned so there is no underflow:
  - Up needs ypos > PLAYER_SIZE.
  - Down needs ypos+1 < SCREEN_HEIGHT-PLAYER_SIZE.
  - Right needs xpos+1 < SCREEN_WIDTH-PLAYER_SIZE.
  - Left needs xpos > PLAYER_SIZE.
  - A chosen direction that fails its bound leaves the position unchanged. Do not fall through to a lower-priority direction.
- Hit is combinational from registered xpos/ypos and point_x/point_y:
  - Condition: |xpos−point_x| < PLAYER_SIZE+POINT_SIZE and |ypos−point_y| < PLAYER_SIZE+POINT_SIZE, using 11-bit absolute difference.
  - Evaluated only in PLAY. The FSM acts on it in the same cycle it is true.
- Same cycle as a hit, a tick still updates the position. The RESPAWN/WIN transition takes effect regardless.
- In RESPAWN and WIN, position and score are frozen and buttons are ignored.
- respawn_ack outside RESPAWN is ignored. respawn_ack in the first RESPAWN cycle completes the handshake next cycle.
- start held high in PLAY or RESPAWN has no effect.
- score saturates at SCORE_MAX and never wraps.
- rst_n asserted mid-handshake drops respawn_req at once.

Optional Feature:
DIAGONAL_MOVE_EN
- Defined: vertical (up > down) and horizontal (right > left) are arbitrated independently. One tick may change both xpos and ypos, each bound-checked separately.
- Undefined: single-axis fixed priority as above.

Test Plan:
- TICK_DIV=4, reset, start=1, move_right held 12 cycles → tick every 4th cycle, xpos 32→35, ypos=32.
- move_up and move_right both held, ypos=17, PLAYER_SIZE=16 → up wins, ypos=16 after one tick, xpos unchanged. The next tick does not move (no fallthrough).
- point at (48,32), player moves right from 32 → the hit fires when xpos−point gap <24 (immediate). score=1, state=RESPAWN, respawn_req=1 until 1 cycle after ack, then PLAY.
- SCORE_MAX=2, two hits → state=WIN, score=2, buttons ignored. start → xpos=32, ypos=32, score=0, PLAY.
- move_down held with collision_down=1 for 5 ticks → ypos constant. Drop the collision → ypos increments by 1 per tick.
- rst_n low during RESPAWN with req=1 → respawn_req=0, state=IDLE, score=0 asynchronously.
